sign_ext: RTL and testbench
===========================

// Module: sign_ext
// PURPOSE
//   Immediate generator for the RV32I single-cycle core.
//   - Decodes the opcode of a 32-bit instruction and assembles its I/S/B/U/J immediate.
//   - Sign-extends the immediate to 32 bits.
//   - Registers the result for the ALU operand mux and the branch/jump target adder.
//   - Flags opcodes that carry no immediate.
// PARAMETERS
//   XLEN  32  datapath width; only 32 is supported.
// PORTS
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   instruct   in   32    instruction word; opcode is instruct[6:0]
//   out        out  32    registered sign-extended immediate
//   imm_type   out  3     registered format: 0=none 1=I 2=S 3=B 4=U 5=J
//   no_imm     out  1     registered; 1 when the opcode has no immediate
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low.
//   - Reset: while rst_n=0, out=32'h0, imm_type=0, no_imm=1, independent of clk.
//   - Latency: combinational decode of instruct; all outputs load on every rising clk edge.
//     The result for the value present at edge N appears at edge N; there is no enable.
//   - Opcode decode and immediate assembly (i = instruct):
//       0010011 OP-IMM, 0000011 LOAD, 1100111 JALR:
//         I-type, imm = {{20{i[31]}}, i[31:20]}
//       0100011 STORE:
//         S-type, imm = {{20{i[31]}}, i[31:25], i[11:7]}
//       1100011 BRANCH:
//         B-type, imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}
//       0110111 LUI, 0010111 AUIPC:
//         U-type, imm = {i[31:12], 12'h0}
//       1101111 JAL:
//         J-type, imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}
//       any other opcode (R-type, SYSTEM, FENCE, illegal):
//         out=0, imm_type=0, no_imm=1
//   - funct3/funct7 are ignored; OP-IMM shifts use the plain I-type rule.
//     imm[11:5] of a shift is then the funct7 field as-is.
//   - Sign bit is always i[31]; the upper bits of out are copies of it for I/S/B/J.
//   - Extremes: 12-bit -2048 -> 32'hFFFFF800; +2047 -> 32'h000007FF.
//   - Reset mid-operation: outputs clear immediately.
//     Normal loading resumes at the first rising edge after rst_n returns high.
//   - No X propagation from a known instruct; every decode path assigns all outputs.
// TESTING
//   - Reset: rst_n=0 with instruct=32'hFFF00093 ->
//     out=0, imm_type=0, no_imm=1 before any clk edge.
//   - I-type: 32'h00000093 -> 0.
//     32'hFFF00093 -> FFFFFFFF.
//     32'h80000093 -> FFFFF800.
//     32'h7FF00093 -> 000007FF.
//     All with imm_type=1, one edge after apply.
//   - LOAD: 32'h00002003 -> 0.
//     32'hFFF02003 -> FFFFFFFF.
//     32'h80002003 -> FFFFF800.
//     32'h7FF02003 -> 000007FF.
//     All with imm_type=1.
//   - STORE: 32'h00002023 -> 0.
//     32'hFFF02023 -> FFFFFFE0.
//     32'h80002023 -> FFFFF800.
//     32'h7FF02023 -> 000007E0.
//     All with imm_type=2.
//   - B/U/J:
//     32'hFE000EE3 (beq -4) -> FFFFFFFC, imm_type=3.
//     32'h123450B7 (lui) -> 12345000, imm_type=4.
//     32'hFFDFF0EF (jal -4) -> FFFFFFFC, imm_type=5.
//   - No-immediate: 32'h002081B3 (add) -> out=0, imm_type=0, no_imm=1.
//     Then assert rst_n=0 mid-stream -> outputs clear without a clock edge.

Source files
------------

// File: rtl/sign_ext.sv
// RV32I immediate generator: decodes the opcode, assembles the I/S/B/U/J
// immediate, sign-extends it and registers it with its format code.
module sign_ext #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instruct,
  output logic [XLEN-1:0] out,
  output logic [2:0]      imm_type,
  output logic            no_imm
);

  localparam int unsigned OPW   = 7;
  localparam int unsigned TYPEW = 3;

  typedef enum logic [TYPEW-1:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  localparam logic [OPW-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPW-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPW-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;

  logic [OPW-1:0]  opcode_c;
  logic [XLEN-1:0] imm_c;
  imm_fmt_e        fmt_c;
  logic            no_imm_c;

  assign opcode_c = instruct[OPW-1:0];

  // Opcode decode and immediate assembly; unknown opcodes fall to the defaults
  always_comb begin
    imm_c    = '0;
    fmt_c    = IMM_NONE;
    no_imm_c = 1'b1;
    unique case (opcode_c)
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm_c    = {{20{instruct[31]}}, instruct[31:20]};
        fmt_c    = IMM_I;
        no_imm_c = 1'b0;
      end
      OP_STORE: begin
        imm_c    = {{20{instruct[31]}}, instruct[31:25], instruct[11:7]};
        fmt_c    = IMM_S;
        no_imm_c = 1'b0;
      end
      OP_BRANCH: begin
        imm_c    = {{19{instruct[31]}}, instruct[31], instruct[7],
                    instruct[30:25], instruct[11:8], 1'b0};
        fmt_c    = IMM_B;
        no_imm_c = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        imm_c    = {instruct[31:12], 12'h000};
        fmt_c    = IMM_U;
        no_imm_c = 1'b0;
      end
      OP_JAL: begin
        imm_c    = {{11{instruct[31]}}, instruct[31], instruct[19:12],
                    instruct[20], instruct[30:21], 1'b0};
        fmt_c    = IMM_J;
        no_imm_c = 1'b0;
      end
      default: begin
        imm_c    = '0;
        fmt_c    = IMM_NONE;
        no_imm_c = 1'b1;
      end
    endcase
  end

  // Output register, loads every edge; reset clears without a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      imm_type <= IMM_NONE;
      no_imm   <= 1'b1;
    end else begin
      out      <= imm_c;
      imm_type <= fmt_c;
      no_imm   <= no_imm_c;
    end
  end

endmodule

// File: tb/tb_sign_ext.sv
// Scoreboard bench for sign_ext: directed instruction words with
// hand-computed immediates, plus asynchronous reset checks.
module tb_sign_ext;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruct;
  logic [31:0] out;
  logic [2:0]  imm_type;
  logic        no_imm;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp_out;
    logic [2:0]  exp_type;
    logic        exp_no_imm;
  } exp_t;

  exp_t exp_q[$];

  sign_ext #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instruct (instruct),
    .out      (out),
    .imm_type (imm_type),
    .no_imm   (no_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_outs(input string name, input logic [31:0] e_out,
                            input logic [2:0] e_type, input logic e_no);
    check_val({name, ".out"}, out, e_out);
    check_val({name, ".imm_type"}, 32'(imm_type), 32'(e_type));
    check_val({name, ".no_imm"}, 32'(no_imm), 32'(e_no));
  endtask

  // Driver: present the word on the falling edge and queue its expectation
  task automatic apply(input string name, input logic [31:0] ins,
                       input logic [31:0] e_out, input logic [2:0] e_type);
    exp_t e;
    @(negedge clk);
    instruct     = ins;
    e.name       = name;
    e.exp_out    = e_out;
    e.exp_type   = e_type;
    e.exp_no_imm = (e_type == 3'd0);
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d results never observed, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: outputs load every rising edge, so compare just after each one
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_outs(e.name, e.exp_out, e.exp_type, e.exp_no_imm);
    end
  end

  initial begin
    rst_n    = 1'b1;
    instruct = 32'hFFF00093;
    #1 rst_n = 1'b0;
    #1;
    check_outs("reset_async", 32'h0, 3'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    apply("addi_0",     32'h00000093, 32'h00000000, 3'd1);
    apply("addi_m1",    32'hFFF00093, 32'hFFFFFFFF, 3'd1);
    apply("addi_min",   32'h80000093, 32'hFFFFF800, 3'd1);
    apply("addi_max",   32'h7FF00093, 32'h000007FF, 3'd1);
    apply("lw_0",       32'h00002003, 32'h00000000, 3'd1);
    apply("lw_m1",      32'hFFF02003, 32'hFFFFFFFF, 3'd1);
    apply("lw_min",     32'h80002003, 32'hFFFFF800, 3'd1);
    apply("lw_max",     32'h7FF02003, 32'h000007FF, 3'd1);
    apply("sw_0",       32'h00002023, 32'h00000000, 3'd2);
    apply("sw_m1",      32'hFFF02023, 32'hFFFFFFE0, 3'd2);
    apply("sw_min",     32'h80002023, 32'hFFFFF800, 3'd2);
    apply("sw_max",     32'h7FF02023, 32'h000007E0, 3'd2);
    apply("beq_m4",     32'hFE000EE3, 32'hFFFFFFFC, 3'd3);
    apply("lui",        32'h123450B7, 32'h12345000, 3'd4);
    apply("auipc",      32'hFFFFF097, 32'hFFFFF000, 3'd4);
    apply("jal_m4",     32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5);
    apply("jalr_8",     32'h00808067, 32'h00000008, 3'd1);
    apply("srai_funct7",32'h4030D093, 32'h00000403, 3'd1);
    apply("add",        32'h002081B3, 32'h00000000, 3'd0);
    apply("lui_again",  32'h800000B7, 32'h80000000, 3'd4);
    apply("ecall",      32'h00000073, 32'h00000000, 3'd0);
    apply("jal_pos",    32'h0080006F, 32'h00000008, 3'd5);
    drain("drain_main");

    // Mid-stream reset must clear outputs with no clock edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_outs("reset_mid", 32'h0, 3'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_reset_sw", 32'hFFF02023, 32'hFFFFFFE0, 3'd2);
    drain("drain_post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
